rx_decoder_66b_64b: RTL and testbench
=====================================

Name: rx_decoder_66b_64b

Overview:
Single-lane 64b/66b receive path. It is the counterpart of the transmit encoder and its scrambler_64bit instances.
- Accepts 66-bit blocks from the upstream gearbox: header in bits [1:0], scrambled payload in bits [65:2].
- Acquires and monitors block lock from the sync headers, and pulses slip to the gearbox until alignment is found.
- Self-synchronously descrambles the payload with x^58+x^39+1 and presents header + 64-bit payload to the PCS decode logic.
- Multi-lane receivers instantiate one copy per lane.

Parameters:
LOCK_COUNT, 64, consecutive valid headers needed to declare lock.
BAD_LIMIT, 16, invalid headers within one LOCK_COUNT window that drop lock.
SLIP_WAIT, 32, valid input blocks ignored after each slip pulse so the gearbox can settle (minimum 1).
REVERSE, 0, 1 = payload bit order reversed before descrambling and restored after, matching scrambler_64bit REVERSE.

Ports:
clk  in  1  receive clock.
rst  in  1  reset.
rx_valid  in  1  rx_data_in holds a block this cycle.
rx_data_in  in  66  [1:0] sync header, [65:2] scrambled payload.
descramble_bypass  in  1  1 = payload passes through unscrambled (EEE/test); descrambler state still updates.
rx_data_out  out  64  descrambled payload.
rx_header_out  out  2  sync header of the block on rx_data_out.
rx_valid_out  out  1  rx_data_out/rx_header_out valid.
block_lock  out  1  block lock achieved.
slip  out  1  one-cycle request to the gearbox to shift alignment by one bit.
hdr_err  out  1  pulse: the block just accepted had an invalid header (00/11).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; FSM in HUNT; all counters 0; descrambler state 0.
- Gating: only cycles with rx_valid=1 advance the FSM, counters, SLIP_WAIT count and descrambler. With rx_valid=0 everything holds, and rx_valid_out and hdr_err are 0 the next cycle.
- Valid header: 2'b01 (data) or 2'b10 (control).
- Latency: 1 clk. The registered outputs follow an accepted block by one cycle.
  - rx_valid_out = that block's rx_valid AND the block_lock value in effect when it was accepted, i.e. before that block's own FSM update.
  - rx_header_out passes through unchanged.
  - hdr_err is asserted in all states.
- Descrambler: out[i] = s[i] ^ s[i-39] ^ s[i-58] over the 58-bit history of received scrambled bits, bit 0 first (after the optional REVERSE).
  - History shifts in the scrambled bits every accepted block, regardless of lock or bypass.
  - Output is correct from the second block after reset.
- FSM state HUNT (block_lock=0):
  - Each valid header increments good_cnt.
  - When good_cnt reaches LOCK_COUNT, set block_lock=1 on the next edge, clear counters, go to LOCKED.
  - An invalid header pulses slip (1 cycle), clears good_cnt and goes to SLIP_HOLD.
  - An invalid header arriving where the LOCK_COUNT-th valid one would be: slip wins.
- FSM state SLIP_HOLD:
  - Counts SLIP_WAIT accepted blocks, ignoring their headers (hdr_err still reported), then returns to HUNT.
  - slip is never re-asserted while in SLIP_HOLD.
- FSM state LOCKED (block_lock=1):
  - win_cnt counts accepted blocks; bad_cnt counts invalid headers.
  - If bad_cnt reaches BAD_LIMIT: clear block_lock, pulse slip, clear counters, go to SLIP_HOLD.
  - Otherwise, when win_cnt reaches LOCK_COUNT: clear win_cnt and bad_cnt and stay LOCKED.
  - If the BAD_LIMIT-th bad header lands on the window's last block, loss of lock wins.
- Widths: counters are $clog2(max parameter)+1 bits and saturate; they never wrap.
- Reset mid-operation: everything returns to reset values immediately. No slip is issued on reset.
- descramble_bypass: takes effect on the next accepted block. Toggling it never corrupts the history.

Decomposition:
Package rx66_pkg:
- SH_DATA = 2'b01, SH_CTRL = 2'b10.
- Typedef lock_state_t {HUNT, SLIP_HOLD, LOCKED}.
- Descrambler tap constants 39 and 58.

Sub-module descrambler_64bit (clk, rst, en, bypass, data_in[63:0], data_out[63:0], REVERSE):
- 58-bit history and a registered output.
- Mirrors scrambler_64bit.

Test Plan:
- Lock acquisition: reset, then 64 blocks with header 01 on consecutive rx_valid cycles -> block_lock rises 1 clk after the 64th block. slip is never asserted. rx_valid_out first high for block 65.
- Hunt slip: 10 good headers then header 11 -> slip high for exactly 1 cycle and hdr_err pulses. The next 32 blocks are ignored, slip stays 0. Then 64 good headers -> block_lock=1.
- Loss of lock: while locked, 16 header-00 blocks scattered within one 64-block window -> block_lock falls and slip pulses 1 clk after the 16th. With 15 bad per window over 3 windows -> block_lock stays 1.
- Descrambler loopback: random payloads through scrambler_64bit (REVERSE 0 and 1), headers 01/10 -> from the 2nd block, rx_data_out equals the original payload. With bypass=1, rx_data_out equals the scrambled payload.
- Gaps and reset: rx_valid toggling 1/0 during lock acquisition -> lock after the 64th valid block, not the 64th cycle. rst asserted mid-LOCKED -> block_lock, rx_valid_out and slip go to 0 asynchronously, and reacquisition needs 64 fresh blocks.

Source files
------------

// File: rtl/rx_decoder_66b_64b_pkg.sv
// Shared constants and types for the 64b/66b receive path.
package rx66_pkg;
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {HUNT, SLIP_HOLD, LOCKED} lock_state_t;

  // x^58 + x^39 + 1
  localparam int TAP_A = 39;
  localparam int TAP_B = 58;

  function automatic logic [63:0] bit_rev64(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction
endpackage

// File: rtl/rx_decoder_66b_64b_descrambler.sv
// Self-synchronous x^58+x^39+1 descrambler, 64 bits per enabled cycle, registered output.
module descrambler_64bit
  import rx66_pkg::*;
#(
  parameter bit REVERSE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bypass,
  input  logic [63:0] data_in,
  output logic [63:0] data_out
);
  logic [57:0]  hist;
  logic [63:0]  s, d;
  logic [121:0] ext;

  // ext[58+i] is payload bit i; ext[0..57] are the previous 58 scrambled bits, oldest at 0
  always_comb begin
    s   = REVERSE ? bit_rev64(data_in) : data_in;
    ext = {s, hist};
    d   = '0;
    for (int i = 0; i < 64; i++)
      d[i] = ext[TAP_B+i] ^ ext[TAP_B-TAP_A+i] ^ ext[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= '0;
      data_out <= '0;
    end else if (en) begin
      hist     <= s[63:64-TAP_B];
      data_out <= bypass ? data_in : (REVERSE ? bit_rev64(d) : d);
    end
  end
endmodule

// File: rtl/rx_decoder_66b_64b.sv
// Single-lane 64b/66b receive path: sync-header block lock, gearbox slip control, descrambling.
module rx_decoder_66b_64b
  import rx66_pkg::*;
#(
  parameter int LOCK_COUNT = 64,
  parameter int BAD_LIMIT  = 16,
  parameter int SLIP_WAIT  = 32,
  parameter bit REVERSE    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [65:0] rx_data_in,
  input  logic        descramble_bypass,
  output logic [63:0] rx_data_out,
  output logic [1:0]  rx_header_out,
  output logic        rx_valid_out,
  output logic        block_lock,
  output logic        slip,
  output logic        hdr_err
);
  localparam int MAXP = (LOCK_COUNT > BAD_LIMIT)
                        ? ((LOCK_COUNT > SLIP_WAIT) ? LOCK_COUNT : SLIP_WAIT)
                        : ((BAD_LIMIT  > SLIP_WAIT) ? BAD_LIMIT  : SLIP_WAIT);
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] BAD_C  = CW'(BAD_LIMIT);
  localparam logic [CW-1:0] WAIT_C = CW'(SLIP_WAIT);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  lock_state_t   state;
  logic [CW-1:0] good_cnt, win_cnt, bad_cnt, wait_cnt;
  logic [CW-1:0] good_inc, win_inc, bad_inc, wait_inc;
  logic [1:0]    hdr;
  logic          hdr_ok;

  assign hdr      = rx_data_in[1:0];
  assign hdr_ok   = (hdr == SH_DATA) || (hdr == SH_CTRL);
  assign good_inc = sat_inc(good_cnt);
  assign win_inc  = sat_inc(win_cnt);
  assign bad_inc  = hdr_ok ? bad_cnt : sat_inc(bad_cnt);
  assign wait_inc = sat_inc(wait_cnt);

  descrambler_64bit #(.REVERSE(REVERSE)) u_descr (
    .clk      (clk),
    .rst      (rst),
    .en       (rx_valid),
    .bypass   (descramble_bypass),
    .data_in  (rx_data_in[65:2]),
    .data_out (rx_data_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      good_cnt      <= '0;
      win_cnt       <= '0;
      bad_cnt       <= '0;
      wait_cnt      <= '0;
      block_lock    <= 1'b0;
      slip          <= 1'b0;
      hdr_err       <= 1'b0;
      rx_valid_out  <= 1'b0;
      rx_header_out <= '0;
    end else begin
      slip         <= 1'b0;
      hdr_err      <= rx_valid & ~hdr_ok;
      // qualify with the lock seen by this block, before its own FSM update
      rx_valid_out <= rx_valid & block_lock;
      if (rx_valid) begin
        rx_header_out <= hdr;
        case (state)
          HUNT: begin
            if (!hdr_ok) begin
              slip     <= 1'b1;
              good_cnt <= '0;
              wait_cnt <= '0;
              state    <= SLIP_HOLD;
            end else if (good_inc >= LOCK_C) begin
              block_lock <= 1'b1;
              good_cnt   <= '0;
              win_cnt    <= '0;
              bad_cnt    <= '0;
              state      <= LOCKED;
            end else begin
              good_cnt <= good_inc;
            end
          end
          SLIP_HOLD: begin
            if (wait_inc >= WAIT_C) begin
              wait_cnt <= '0;
              state    <= HUNT;
            end else begin
              wait_cnt <= wait_inc;
            end
          end
          LOCKED: begin
            // loss of lock takes priority over the window rollover
            if (bad_inc >= BAD_C) begin
              block_lock <= 1'b0;
              slip       <= 1'b1;
              win_cnt    <= '0;
              bad_cnt    <= '0;
              wait_cnt   <= '0;
              state      <= SLIP_HOLD;
            end else if (win_inc >= LOCK_C) begin
              win_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              win_cnt <= win_inc;
              bad_cnt <= bad_inc;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_decoder_66b_64b.sv
// Directed bench: lock/slip FSM sequences plus a table of descrambler loopback vectors.
module tb_rx_decoder_66b_64b;
  import rx66_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [65:0] rx_data_in = '0;
  logic [65:0] rx_data_in_r = '0;
  logic        descramble_bypass = 1'b0;
  logic [63:0] rx_data_out, rx_data_out_r;
  logic [1:0]  rx_header_out, rx_header_out_r;
  logic        rx_valid_out, rx_valid_out_r, block_lock, block_lock_r;
  logic        slip, slip_r, hdr_err, hdr_err_r;

  int n_cmp = 0;
  int n_fail = 0;
  logic any_slip, any_vout, lock_lo;
  int err_cnt;

  always #5 clk = ~clk;

  rx_decoder_66b_64b #(.REVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data_in(rx_data_in),
    .descramble_bypass(descramble_bypass), .rx_data_out(rx_data_out),
    .rx_header_out(rx_header_out), .rx_valid_out(rx_valid_out),
    .block_lock(block_lock), .slip(slip), .hdr_err(hdr_err));

  rx_decoder_66b_64b #(.REVERSE(1'b1)) dut_r (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data_in(rx_data_in_r),
    .descramble_bypass(descramble_bypass), .rx_data_out(rx_data_out_r),
    .rx_header_out(rx_header_out_r), .rx_valid_out(rx_valid_out_r),
    .block_lock(block_lock_r), .slip(slip_r), .hdr_err(hdr_err_r));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    any_slip = 1'b0; any_vout = 1'b0; lock_lo = 1'b0; err_cnt = 0;
  endtask

  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] p, input logic [63:0] pr);
    rx_valid = v;
    rx_data_in = {p, h};
    rx_data_in_r = {pr, h};
    @(posedge clk); #1;
    if (slip) any_slip = 1'b1;
    if (rx_valid_out) any_vout = 1'b1;
    if (hdr_err) err_cnt++;
    if (!block_lock) lock_lo = 1'b1;
  endtask

  task automatic send_n(input int n, input logic [1:0] h);
    for (int i = 0; i < n; i++) step(1'b1, h, 64'd0, 64'd0);
  endtask

  // serial reference scrambler; h[k] is the scrambled bit k+1 positions ago
  task automatic scramble(input logic [63:0] d, input bit rev, input logic [57:0] hin,
                          output logic [63:0] q, output logic [57:0] hout);
    logic [63:0] dd, qq;
    logic [57:0] h;
    logic b;
    h = hin; qq = '0;
    for (int i = 0; i < 64; i++) dd[i] = rev ? d[63-i] : d[i];
    for (int i = 0; i < 64; i++) begin
      b = dd[i] ^ h[38] ^ h[57];
      qq[i] = b;
      h = {h[56:0], b};
    end
    for (int i = 0; i < 64; i++) q[i] = rev ? qq[63-i] : qq[i];
    hout = h;
  endtask

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] pay;
    logic        byp;
    logic        exp_err;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [57:0] st0, st1;
    logic [63:0] s0, s1;

    tbl[0] = '{SH_DATA, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
    tbl[1] = '{SH_CTRL, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[2] = '{SH_DATA, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0};
    tbl[3] = '{SH_DATA, 64'h8000_0000_0000_0001, 1'b0, 1'b0};
    tbl[4] = '{2'b00,   64'h5555_AAAA_5555_AAAA, 1'b0, 1'b1};
    tbl[5] = '{SH_CTRL, 64'h1E00_0000_0000_0000, 1'b1, 1'b0};
    tbl[6] = '{SH_CTRL, 64'h0000_0000_0000_0000, 1'b0, 1'b0};
    tbl[7] = '{2'b11,   64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 1'b1};
    tbl[8] = '{SH_DATA, 64'h7654_3210_FEDC_BA98, 1'b0, 1'b0};
    tbl[9] = '{SH_DATA, 64'h0000_0001_0000_0000, 1'b0, 1'b0};

    // reset values
    #1 rst = 1'b1;
    #2;
    check("rst_data", rx_data_out, 64'd0);
    check("rst_hdr", {62'd0, rx_header_out}, 64'd0);
    check("rst_vout", {63'd0, rx_valid_out}, 64'd0);
    check("rst_lock", {63'd0, block_lock}, 64'd0);
    check("rst_slip", {63'd0, slip}, 64'd0);
    check("rst_herr", {63'd0, hdr_err}, 64'd0);
    #19 rst = 1'b0;

    // lock acquisition
    clr_mon();
    send_n(63, SH_DATA);
    check("acq_lock_at63", {63'd0, block_lock}, 64'd0);
    send_n(1, SH_DATA);
    check("acq_lock_at64", {63'd0, block_lock}, 64'd1);
    check("acq_vout_blk64", {63'd0, rx_valid_out}, 64'd0);
    check("acq_no_slip", {63'd0, any_slip}, 64'd0);
    check("acq_vout_early", {63'd0, any_vout}, 64'd0);
    send_n(1, SH_DATA);
    check("acq_vout_blk65", {63'd0, rx_valid_out}, 64'd1);

    // 15 bad headers per window across 3 windows keeps lock
    clr_mon();
    for (int w = 0; w < 3; w++)
      for (int j = (w == 0) ? 1 : 0; j < 64; j++)
        step(1'b1, (j % 4 == 1 && j < 60) ? 2'b00 : SH_CTRL, 64'd0, 64'd0);
    check("bad15_lock_held", {63'd0, lock_lo}, 64'd0);
    check("bad15_herr_cnt", 64'(err_cnt), 64'd45);
    check("bad15_no_slip", {63'd0, any_slip}, 64'd0);

    // 16th bad header in a window drops lock
    clr_mon();
    for (int j = 0; j < 61; j++)
      step(1'b1, (j % 4 == 1) ? 2'b00 : SH_DATA, 64'd0, 64'd0);
    check("bad16_held_before", {63'd0, lock_lo}, 64'd0);
    step(1'b1, 2'b00, 64'd0, 64'd0);
    check("bad16_lock", {63'd0, block_lock}, 64'd0);
    check("bad16_slip", {63'd0, slip}, 64'd1);
    clr_mon();
    send_n(32, 2'b11);
    check("hold_no_slip", {63'd0, any_slip}, 64'd0);
    check("hold_herr_cnt", 64'(err_cnt), 64'd32);

    // hunt slip after 10 good headers
    send_n(10, SH_DATA);
    send_n(1, 2'b11);
    check("hunt_slip", {63'd0, slip}, 64'd1);
    check("hunt_herr", {63'd0, hdr_err}, 64'd1);
    send_n(1, 2'b00);
    check("hunt_slip_1cyc", {63'd0, slip}, 64'd0);
    clr_mon();
    send_n(31, 2'b00);
    check("hunt_hold_no_slip", {63'd0, any_slip}, 64'd0);

    // invalid header in the 64th slot: slip wins over lock
    send_n(63, SH_DATA);
    send_n(1, 2'b00);
    check("slipwin_slip", {63'd0, slip}, 64'd1);
    check("slipwin_lock", {63'd0, block_lock}, 64'd0);
    clr_mon();
    send_n(32, 2'b00);
    check("slipwin_hold", {63'd0, any_slip}, 64'd0);
    send_n(63, SH_CTRL);
    check("relock_at63", {63'd0, block_lock}, 64'd0);
    send_n(1, SH_CTRL);
    check("relock_at64", {63'd0, block_lock}, 64'd1);

    // 16th bad header on the window's last block: loss wins
    clr_mon();
    for (int j = 0; j < 63; j++)
      step(1'b1, (j % 4 == 3) ? 2'b00 : SH_DATA, 64'd0, 64'd0);
    check("lastblk_held", {63'd0, lock_lo}, 64'd0);
    step(1'b1, 2'b00, 64'd0, 64'd0);
    check("lastblk_lock", {63'd0, block_lock}, 64'd0);
    check("lastblk_slip", {63'd0, slip}, 64'd1);
    send_n(32, SH_DATA);

    // gaps: lock counts valid blocks, not cycles
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    clr_mon();
    for (int k = 0; k < 63; k++) begin
      step(1'b1, SH_DATA, 64'd0, 64'd0);
      step(1'b0, 2'b00, 64'd0, 64'd0);
    end
    check("gap_lock_at63", {63'd0, block_lock}, 64'd0);
    check("gap_herr_gated", 64'(err_cnt), 64'd0);
    check("gap_no_vout", {63'd0, any_vout}, 64'd0);
    step(1'b1, SH_DATA, 64'd0, 64'd0);
    check("gap_lock_at64", {63'd0, block_lock}, 64'd1);
    step(1'b0, SH_DATA, 64'd0, 64'd0);
    check("gap_vout_idle", {63'd0, rx_valid_out}, 64'd0);
    step(1'b1, SH_DATA, 64'd0, 64'd0);
    check("gap_vout_locked", {63'd0, rx_valid_out}, 64'd1);

    // asynchronous reset mid-lock
    #2 rst = 1'b1;
    #1;
    check("arst_lock", {63'd0, block_lock}, 64'd0);
    check("arst_vout", {63'd0, rx_valid_out}, 64'd0);
    check("arst_slip", {63'd0, slip}, 64'd0);
    #2 rst = 1'b0;
    clr_mon();
    send_n(63, SH_DATA);
    check("arst_relock_at63", {63'd0, block_lock}, 64'd0);
    check("arst_no_slip", {63'd0, any_slip}, 64'd0);
    send_n(1, SH_DATA);
    check("arst_relock_at64", {63'd0, block_lock}, 64'd1);

    // descrambler loopback table; history is all-zero here since only zero payloads were sent
    st0 = '0; st1 = '0;
    for (int i = 0; i < 10; i++) begin
      scramble(tbl[i].pay, 1'b0, st0, s0, st0);
      scramble(tbl[i].pay, 1'b1, st1, s1, st1);
      descramble_bypass = tbl[i].byp;
      step(1'b1, tbl[i].hdr, s0, s1);
      check($sformatf("tbl%0d_data", i), rx_data_out, tbl[i].byp ? s0 : tbl[i].pay);
      check($sformatf("tbl%0d_data_rev", i), rx_data_out_r, tbl[i].byp ? s1 : tbl[i].pay);
      check($sformatf("tbl%0d_hdr", i), {62'd0, rx_header_out}, {62'd0, tbl[i].hdr});
      check($sformatf("tbl%0d_herr", i), {63'd0, hdr_err}, {63'd0, tbl[i].exp_err});
      check($sformatf("tbl%0d_vout", i), {63'd0, rx_valid_out}, 64'd1);
    end
    descramble_bypass = 1'b0;
    rx_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
